hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the 5-stage MIPS datapath. It drives the program counter's `PC_Write` enable, the IF/ID register write enable and the ID/EX bubble. It detects load-use and branch-operand hazards between ID and the EX/MEM stages and holds fetch for a fixed, latched number of cycles. Two saturating counters record stall activity for performance reporting.

## Interface
Parameters:
- `REG_W`, 5: register-address width.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `Clk`, in, 1: clock. All state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `ID_Rs`, in, `REG_W`: source register rs of the instruction in ID.
- `ID_Rt`, in, `REG_W`: source register rt of the instruction in ID.
- `ID_UsesRt`, in, 1: the ID instruction reads rt.
- `ID_IsBranch`, in, 1: the ID instruction is a branch resolved in ID (beq/bne/bgez/…).
- `EX_MemRead`, in, 1: the EX instruction is a load.
- `EX_RegWrite`, in, 1: the EX instruction writes the register file.
- `EX_WriteReg`, in, `REG_W`: destination register of the EX instruction.
- `MEM_MemRead`, in, 1: the MEM instruction is a load.
- `MEM_WriteReg`, in, `REG_W`: destination register of the MEM instruction.
- `PC_Write`, out, 1: PC register enable.
- `IFID_Write`, out, 1: IF/ID register enable.
- `IDEX_Flush`, out, 1: zero the ID/EX control bits (insert a bubble).
- `StallCycles`, out, `CNT_W`: count of cycles with `PC_Write`=0. Saturates.
- `HazardEvents`, out, `CNT_W`: count of hazards detected in state RUN. Saturates.

## Operation
**Match rule.** Define `dep(R)` as true when `R != 0` and (`R == ID_Rs`, or `ID_UsesRt` and `R == ID_Rt`). Register 0 never causes a hazard.

**Required stall length N**, evaluated combinationally. The largest applicable value wins:
- N=2: `ID_IsBranch` and `EX_MemRead` and `dep(EX_WriteReg)`.
- N=1: `EX_MemRead` and `dep(EX_WriteReg)`. This is a load-use hazard.
- N=1: `ID_IsBranch` and `EX_RegWrite` and not `EX_MemRead` and `dep(EX_WriteReg)`.
- N=1: `ID_IsBranch` and `MEM_MemRead` and `dep(MEM_WriteReg)`.
- N=0 otherwise.

**FSM states:** RUN, HOLD_LAST.
- RUN with N=0: `PC_Write`=1, `IFID_Write`=1, `IDEX_Flush`=0. Stay in RUN.
- RUN with N≥1: `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1. Increment `HazardEvents`.
  - N=1: next state RUN.
  - N=2: next state HOLD_LAST.
- HOLD_LAST: `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1, regardless of the inputs. Next state RUN. Hazard detection is not evaluated and `HazardEvents` is not incremented.

**Re-evaluation.** On returning to RUN, the hazard check is redone against the current inputs. A residual hazard therefore produces a further stall. This is legal and is counted as a new event.

**Counters.**
- `StallCycles` increments in every cycle where `PC_Write`=0.
- Both counters hold at all-ones; there is no wrap-around.

## Timing
- **Output type.** Outputs are Mealy in RUN (same cycle as the ID inputs) and Moore in HOLD_LAST.
- **Latency.** A stall takes effect at the same edge the hazard is presented: the PC does not advance at the end of the detection cycle. Total stalled cycles equal N exactly.
- **Reset.** While `Reset`=1, outputs are `PC_Write`=1, `IFID_Write`=1, `IDEX_Flush`=0. At the edge: state goes to RUN and both counters go to 0.
- **Reset mid-stall.** Reset asserted in HOLD_LAST aborts the hold; the next cycle is RUN.
- **Counter update.** Counters update at the edge ending the counted cycle. Reset has priority over increment.
- **Simultaneous hazards.** A branch-on-load-in-EX alongside a plain load-use yields N=2, not 3. Only one event is counted per detection.

## Structure
- **Shared package** (`pipeline_pkg`):
  - State encoding constants `ST_RUN` and `ST_HOLD_LAST`.
  - `REG_W` default.
  - A `ZERO_REG` constant.
  - The datapath stage modules reuse the same package.
- **Sub-module** `sat_counter`:
  - Parameter `W`.
  - Ports `Clk`, `Reset`, `Inc`, `Count`.
  - Instantiated twice.
- **Top level.** Hazard decode is combinational logic at the top level. The FSM is one two-state register.

## Test plan
- **Load-use.** `EX_MemRead`=1, `EX_WriteReg`=8, `ID_Rs`=8, no branch → exactly 1 cycle with `PC_Write`=0 and `IDEX_Flush`=1, then RUN. `HazardEvents`=1, `StallCycles`=1.
- **Branch on EX load.** `ID_IsBranch`=1, `EX_MemRead`=1, `EX_WriteReg`=9, `ID_Rt`=9, `ID_UsesRt`=1 → 2 consecutive stall cycles. The second cycle holds even if the inputs change to no-hazard. `StallCycles`=2, `HazardEvents`=1.
- **Register 0 and rt gating.**
  - `EX_MemRead`=1, `EX_WriteReg`=0, `ID_Rs`=0 → no stall.
  - `EX_WriteReg`=5, `ID_Rt`=5, `ID_UsesRt`=0 → no stall.
- **Branch on ALU result and on MEM load.**
  - Branch with `EX_RegWrite`=1, `EX_WriteReg`=3, `ID_Rs`=3 → 1 stall.
  - Branch with `MEM_MemRead`=1, `MEM_WriteReg`=3, `ID_Rs`=3 → 1 stall.
  - Branch with `MEM_MemRead`=0 → no stall.
- **Reset mid-stall.** Trigger N=2, then assert `Reset` in HOLD_LAST → outputs are 1/1/0 during reset, counters are 0 afterwards, and the following cycle is RUN with no residual hold.
- **Saturation.** With `CNT_W`=4, hold a load-use hazard for 20 cycles → `StallCycles` and `HazardEvents` stop at 15 with no wrap.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
//   Types and constants shared by the 5-stage MIPS datapath blocks:
//   - REG_W     : default register-address width
//   - ZERO_REG  : the hard-wired $zero register address
//   - hz_state_t: hazard-controller state encoding (ST_RUN, ST_HOLD_LAST)
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_HOLD_LAST = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit_if
//   Bundle between the pipeline datapath and the hazard/stall controller.
//   master : datapath side, drives ID/EX/MEM operand info, receives controls
//   slave  : hazard controller side
//   Signals:
//     ID_Rs, ID_Rt, ID_UsesRt, ID_IsBranch      - instruction in ID
//     EX_MemRead, EX_RegWrite, EX_WriteReg      - instruction in EX
//     MEM_MemRead, MEM_WriteReg                 - instruction in MEM
//     PC_Write, IFID_Write, IDEX_Flush          - stall controls
//     StallCycles, HazardEvents                 - saturating perf counters
// ----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
    parameter int REG_W = pipeline_pkg::REG_W,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRt;
    logic             ID_IsBranch;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [REG_W-1:0] EX_WriteReg;
    logic             MEM_MemRead;
    logic [REG_W-1:0] MEM_WriteReg;

    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Flush;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] HazardEvents;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_IsBranch,
        output EX_MemRead, EX_RegWrite, EX_WriteReg,
        output MEM_MemRead, MEM_WriteReg,
        input  PC_Write, IFID_Write, IDEX_Flush,
        input  StallCycles, HazardEvents
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsBranch,
        input  EX_MemRead, EX_RegWrite, EX_WriteReg,
        input  MEM_MemRead, MEM_WriteReg,
        output PC_Write, IFID_Write, IDEX_Flush,
        output StallCycles, HazardEvents
    );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   W-bit up-counter that sticks at all-ones instead of wrapping.
//   Clk   : clock
//   Reset : synchronous active-high clear (wins over Inc)
//   Inc   : count this cycle
//   Count : current value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    always_ff @(posedge Clk) begin
        if (Reset)
            Count <= '0;
        else if (Inc && (Count != {W{1'b1}}))
            Count <= Count + 1'b1;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
//   Detects load-use and branch-operand hazards between ID and EX/MEM and
//   holds fetch for the required number of cycles (1 or 2), inserting a
//   bubble into ID/EX each stalled cycle.
//   Clk, Reset : clock, synchronous active-high reset
//   hz (slave) : operand info in, PC_Write/IFID_Write/IDEX_Flush and the
//                StallCycles/HazardEvents counters out
// ----------------------------------------------------------------------------
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_W = pipeline_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    hazard_stall_unit_if.slave  hz
);

    hz_state_t state;

    logic ex_dep, mem_dep;
    logic need2, need1;
    logic stall, hz_event;

    // dep(R): R is non-zero and is read by the ID instruction (rt only when used)
    assign ex_dep  = (hz.EX_WriteReg != REG_W'(ZERO_REG)) &&
                     ((hz.EX_WriteReg == hz.ID_Rs) ||
                      (hz.ID_UsesRt && (hz.EX_WriteReg == hz.ID_Rt)));
    assign mem_dep = (hz.MEM_WriteReg != REG_W'(ZERO_REG)) &&
                     ((hz.MEM_WriteReg == hz.ID_Rs) ||
                      (hz.ID_UsesRt && (hz.MEM_WriteReg == hz.ID_Rt)));

    // Branch on a load still in EX needs the load to reach WB: two cycles.
    assign need2 = hz.ID_IsBranch && hz.EX_MemRead && ex_dep;
    assign need1 = (hz.EX_MemRead && ex_dep) ||
                   (hz.ID_IsBranch && hz.EX_RegWrite && !hz.EX_MemRead && ex_dep) ||
                   (hz.ID_IsBranch && hz.MEM_MemRead && mem_dep);

    // Controls are Mealy in RUN so the stall lands on the detection edge;
    // HOLD_LAST stalls unconditionally. Reset forces the free-running values.
    assign stall    = !Reset && ((state == ST_HOLD_LAST) || need1 || need2);
    assign hz_event = !Reset && (state == ST_RUN) && (need1 || need2);

    assign hz.PC_Write   = !stall;
    assign hz.IFID_Write = !stall;
    assign hz.IDEX_Flush = stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:       state <= need2 ? ST_HOLD_LAST : ST_RUN;
                ST_HOLD_LAST: state <= ST_RUN;
                default:      state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (stall),
        .Count (hz.StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_event_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (hz_event),
        .Count (hz.HazardEvents)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_unit
//   Two instances: A with 16-bit counters for the functional vectors, B with
//   4-bit counters for saturation. B shares A's operand inputs but has its
//   own reset. Each driven cycle pushes its hand-computed expectation into a
//   per-DUT queue; monitors pop and compare on the falling edge.
// ----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    logic Clk = 1'b0;
    logic rst_a, rst_b;

    always #5 Clk = ~Clk;

    hazard_stall_unit_if #(.REG_W(5), .CNT_W(16)) ifa ();
    hazard_stall_unit_if #(.REG_W(5), .CNT_W(4))  ifb ();

    hazard_stall_unit #(.REG_W(5), .CNT_W(16)) dut_a (
        .Clk   (Clk),
        .Reset (rst_a),
        .hz    (ifa.slave)
    );

    hazard_stall_unit #(.REG_W(5), .CNT_W(4)) dut_b (
        .Clk   (Clk),
        .Reset (rst_b),
        .hz    (ifb.slave)
    );

    assign ifb.ID_Rs        = ifa.ID_Rs;
    assign ifb.ID_Rt        = ifa.ID_Rt;
    assign ifb.ID_UsesRt    = ifa.ID_UsesRt;
    assign ifb.ID_IsBranch  = ifa.ID_IsBranch;
    assign ifb.EX_MemRead   = ifa.EX_MemRead;
    assign ifb.EX_RegWrite  = ifa.EX_RegWrite;
    assign ifb.EX_WriteReg  = ifa.EX_WriteReg;
    assign ifb.MEM_MemRead  = ifa.MEM_MemRead;
    assign ifb.MEM_WriteReg = ifa.MEM_WriteReg;

    typedef struct {
        logic  pc;
        logic  ifid;
        logic  fl;
        int    sc;
        int    he;
        string name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int failures = 0;

    task automatic cmp(input string name, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", name, what, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (qa.size() > 0) begin
            exp_t e;
            e = qa.pop_front();
            cmp(e.name, "A.PC_Write",     int'(ifa.PC_Write),     int'(e.pc));
            cmp(e.name, "A.IFID_Write",   int'(ifa.IFID_Write),   int'(e.ifid));
            cmp(e.name, "A.IDEX_Flush",   int'(ifa.IDEX_Flush),   int'(e.fl));
            cmp(e.name, "A.StallCycles",  int'(ifa.StallCycles),  e.sc);
            cmp(e.name, "A.HazardEvents", int'(ifa.HazardEvents), e.he);
        end
        if (qb.size() > 0) begin
            exp_t e;
            e = qb.pop_front();
            cmp(e.name, "B.PC_Write",     int'(ifb.PC_Write),     int'(e.pc));
            cmp(e.name, "B.IDEX_Flush",   int'(ifb.IDEX_Flush),   int'(e.fl));
            cmp(e.name, "B.StallCycles",  int'(ifb.StallCycles),  e.sc);
            cmp(e.name, "B.HazardEvents", int'(ifb.HazardEvents), e.he);
        end
    end

    // Operand inputs: rs, rt, uses_rt, branch, ex_mr, ex_rw, ex_wr, mem_mr, mem_wr
    task automatic drv(input int rs, input int rt, input bit urt, input bit br,
                       input bit exmr, input bit exrw, input int exwr,
                       input bit memmr, input int memwr);
        ifa.ID_Rs        = 5'(rs);
        ifa.ID_Rt        = 5'(rt);
        ifa.ID_UsesRt    = urt;
        ifa.ID_IsBranch  = br;
        ifa.EX_MemRead   = exmr;
        ifa.EX_RegWrite  = exrw;
        ifa.EX_WriteReg  = 5'(exwr);
        ifa.MEM_MemRead  = memmr;
        ifa.MEM_WriteReg = 5'(memwr);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expectation for the current cycle; counters are the values before this edge.
    task automatic cyc_a(input string n, input bit pc, input bit fl, input int sc, input int he);
        exp_t e;
        e.pc = pc; e.ifid = pc; e.fl = fl; e.sc = sc; e.he = he; e.name = n;
        qa.push_back(e);
        @(posedge Clk); #1;
    endtask

    task automatic cyc_b(input string n, input bit pc, input bit fl, input int sc, input int he);
        exp_t e;
        e.pc = pc; e.ifid = pc; e.fl = fl; e.sc = sc; e.he = he; e.name = n;
        qb.push_back(e);
        @(posedge Clk); #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle();
        @(posedge Clk); #1;
        // second reset cycle: counters already cleared by the first edge
        cyc_a("reset", 1, 0, 0, 0);
        rst_a = 1'b0;

        idle();                          cyc_a("idle",          1, 0, 0, 0);
        drv(8, 0, 0, 0, 1, 1, 8, 0, 0);  cyc_a("loaduse",       0, 1, 0, 0);
        idle();                          cyc_a("loaduse_after", 1, 0, 1, 1);
        drv(0, 9, 1, 1, 1, 1, 9, 0, 0);  cyc_a("brload_1",      0, 1, 1, 1);
        idle();                          cyc_a("brload_hold",   0, 1, 2, 2);
        idle();                          cyc_a("brload_after",  1, 0, 3, 2);
        drv(0, 0, 0, 0, 1, 1, 0, 0, 0);  cyc_a("reg0",          1, 0, 3, 2);
        drv(1, 5, 0, 0, 1, 1, 5, 0, 0);  cyc_a("rt_unused",     1, 0, 3, 2);
        drv(3, 0, 0, 1, 0, 1, 3, 0, 0);  cyc_a("br_alu",        0, 1, 3, 2);
        idle();                          cyc_a("br_alu_after",  1, 0, 4, 3);
        drv(3, 0, 0, 1, 0, 0, 0, 1, 3);  cyc_a("br_memload",    0, 1, 4, 3);
        drv(3, 0, 0, 1, 0, 0, 0, 0, 3);  cyc_a("br_mem_noload", 1, 0, 5, 4);
        // residual hazard after a 1-cycle stall counts as a new event
        drv(8, 0, 0, 0, 1, 0, 8, 0, 0);  cyc_a("residual_1",    0, 1, 5, 4);
        drv(8, 0, 0, 0, 1, 0, 8, 0, 0);  cyc_a("residual_2",    0, 1, 6, 5);
        idle();                          cyc_a("residual_end",  1, 0, 7, 6);
        // reset while in HOLD_LAST
        drv(0, 9, 1, 1, 1, 0, 9, 0, 0);  cyc_a("rst_mid_det",   0, 1, 7, 6);
        rst_a = 1'b1; idle();            cyc_a("rst_mid_hold",  1, 0, 8, 7);
        rst_a = 1'b0;                    cyc_a("rst_mid_run",   1, 0, 0, 0);
        drv(8, 0, 0, 0, 1, 0, 8, 0, 0);  cyc_a("rst_mid_haz",   0, 1, 0, 0);
        idle();                          cyc_a("rst_mid_end",   1, 0, 1, 1);

        // saturation on the 4-bit instance
        cyc_b("b_reset", 1, 0, 0, 0);
        rst_b = 1'b0;
        drv(8, 0, 0, 0, 1, 0, 8, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc_b($sformatf("sat_%0d", i), 0, 1, (i > 15) ? 15 : i, (i > 15) ? 15 : i);
        idle();                          cyc_b("sat_end",       1, 0, 15, 15);

        @(negedge Clk); #1;
        cmp("drain", "qa_left", qa.size(), 0);
        cmp("drain", "qb_left", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
